uart_tx: RTL and testbench

UART transmitter: serializes one 8-bit byte per transaction onto a single line as an 8N1 frame (start bit, 8 data bits LSB first, one stop bit). It is the transmit counterpart of the team's UART receiver and drives the same serial line format the receiver samples. Bit timing comes from an internal clock-enable counter, so the block runs entirely in the system clock domain with a valid/ready byte interface toward the user logic.

---
 rtl/uart_tx.sv | 119 +++++++++++
 tb/tb_uart_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with an internal bit-timer.
// Valid/ready byte interface; registered serial output idles high.
module uart_tx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_out,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] T_MAX = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [TW-1:0]   timer;
   logic [TW-1:0]   timer_nx;
   logic [2:0]      idx;
   logic [2:0]      idx_nx;
   logic [7:0]      shift;
   logic [7:0]      shift_nx;
   logic            out_nx;
   logic            done_nx;
   logic            bit_end;
   logic [TW-1:0]   timer_inc;

   assign bit_end   = (timer == T_MAX);
   assign timer_inc = bit_end ? '0 : timer + 1'b1;

   always_comb begin
      state_nx = state;
      timer_nx = timer;
      idx_nx   = idx;
      shift_nx = shift;
      out_nx   = tx_out;
      done_nx  = 1'b0;
      unique case (state)
         IDLE: begin
            timer_nx = '0;
            idx_nx   = '0;
            out_nx   = 1'b1;
            if (tx_valid) begin
               shift_nx = tx_data;
               state_nx = START;
               out_nx   = 1'b0;
            end
         end
         START: begin
            timer_nx = timer_inc;
            out_nx   = 1'b0;
            if (bit_end) begin
               state_nx = DATA;
               idx_nx   = '0;
               out_nx   = shift[0];
            end
         end
         DATA: begin
            timer_nx = timer_inc;
            if (bit_end) begin
               if (idx == 3'd7) begin
                  state_nx = STOP;
                  out_nx   = 1'b1;
               end else begin
                  // shift[1] becomes the new LSB after this shift
                  shift_nx = shift >> 1;
                  idx_nx   = idx + 3'd1;
                  out_nx   = shift[1];
               end
            end
         end
         STOP: begin
            timer_nx = timer_inc;
            out_nx   = 1'b1;
            if (bit_end) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            out_nx   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         timer   <= '0;
         idx     <= '0;
         shift   <= '0;
         tx_out  <= 1'b1;
         tx_done <= 1'b0;
      end else begin
         state   <= state_nx;
         timer   <= timer_nx;
         idx     <= idx_nx;
         shift   <= shift_nx;
         tx_out  <= out_nx;
         tx_done <= done_nx;
      end
   end

   assign tx_ready = (state == IDLE);
   assign tx_busy  = (state != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: waveform model at 4 clocks/bit
// and a serial receiver model at 16 clocks/bit.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       v4 = 1'b1;
   logic [7:0] d4 = 8'h55;
   logic       rdy4, out4, busy4, done4;
   logic       v16 = 1'b0;
   logic [7:0] d16 = 8'h00;
   logic       rdy16, out16, busy16, done16;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx #(.CLKS_PER_BIT(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .tx_valid(v4), .tx_data(d4),
      .tx_ready(rdy4), .tx_out(out4), .tx_busy(busy4), .tx_done(done4)
   );

   uart_tx #(.CLKS_PER_BIT(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .tx_valid(v16), .tx_data(d16),
      .tx_ready(rdy16), .tx_out(out16), .tx_busy(busy16), .tx_done(done16)
   );

   // Frame bit i of an 8N1 frame: start, 8 data LSB first, stop.
   function automatic logic frame_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return b[i-1];
      return 1'b1;
   endfunction

   // Expected line c cycles after the accepting edge at 4 clocks/bit.
   function automatic logic line_at(input logic [7:0] b, input int c);
      if (c >= 40) return 1'b1;
      return frame_bit(b, c / 4);
   endfunction

   task automatic accept4(input logic [7:0] b);
      @(posedge clk); #1;
      v4 = 1'b1;
      d4 = b;
      @(posedge clk); #1;
      v4 = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({out4, rdy4, busy4, done4} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_outputs got %b want 1100",
                     {out4, rdy4, busy4, done4});
         end
      end
      @(posedge clk); #1;
      v4 = 1'b0;
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({out4, rdy4, busy4, done4} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_no_frame got %b want 1100",
                     {out4, rdy4, busy4, done4});
         end
      end
   endtask

   task automatic test_single(input logic [7:0] b);
      accept4(b);
      for (int c = 0; c <= 42; c++) begin
         @(negedge clk);
         checks++;
         if (out4 !== line_at(b, c)) begin
            errors++;
            $display("FAIL single_line byte %h cyc %0d got %b want %b",
                     b, c, out4, line_at(b, c));
         end
         checks++;
         if (done4 !== (c == 40)) begin
            errors++;
            $display("FAIL single_done byte %h cyc %0d got %b want %b",
                     b, c, done4, (c == 40));
         end
         checks++;
         if (busy4 !== (c < 40) || rdy4 !== (c >= 40)) begin
            errors++;
            $display("FAIL single_busy cyc %0d got b%b r%b want b%b",
                     c, busy4, rdy4, (c < 40));
         end
      end
   endtask

   task automatic test_back_to_back;
      logic exp;
      @(posedge clk); #1;
      v4 = 1'b1;
      d4 = 8'h00;
      @(posedge clk); #1;
      d4 = 8'hFF;
      for (int c = 0; c <= 84; c++) begin
         @(negedge clk);
         if (c <= 40) exp = line_at(8'h00, c);
         else         exp = line_at(8'hFF, c - 41);
         checks++;
         if (out4 !== exp) begin
            errors++;
            $display("FAIL b2b_line cyc %0d got %b want %b", c, out4, exp);
         end
         checks++;
         if (done4 !== (c == 40 || c == 81)) begin
            errors++;
            $display("FAIL b2b_done cyc %0d got %b want %b",
                     c, done4, (c == 40 || c == 81));
         end
         if (c == 41) v4 = 1'b0;
      end
   endtask

   task automatic test_busy_protect;
      accept4(8'h81);
      for (int c = 0; c <= 46; c++) begin
         @(negedge clk);
         checks++;
         if (out4 !== line_at(8'h81, c)) begin
            errors++;
            $display("FAIL busy_line cyc %0d got %b want %b",
                     c, out4, line_at(8'h81, c));
         end
         checks++;
         if (done4 !== (c == 40)) begin
            errors++;
            $display("FAIL busy_done cyc %0d got %b want %b",
                     c, done4, (c == 40));
         end
         if (c == 17) begin
            v4 = 1'b1;
            d4 = 8'h3C;
         end
         if (c == 18) v4 = 1'b0;
      end
   endtask

   task automatic test_reset_mid;
      logic [7:0] b;
      b = 8'($urandom);
      accept4(b);
      for (int c = 0; c < 26; c++) begin
         @(negedge clk);
         checks++;
         if (out4 !== line_at(b, c)) begin
            errors++;
            $display("FAIL rstmid_line cyc %0d got %b want %b",
                     c, out4, line_at(b, c));
         end
         if (c == 25) rst_n = 1'b0;
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if ({out4, rdy4, busy4, done4} !== 4'b1100) begin
            errors++;
            $display("FAIL rstmid_held cyc %0d got %b want 1100",
                     c, {out4, rdy4, busy4, done4});
         end
      end
      rst_n = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         checks++;
         if ({out4, rdy4, busy4, done4} !== 4'b1100) begin
            errors++;
            $display("FAIL rstmid_after cyc %0d got %b want 1100",
                     c, {out4, rdy4, busy4, done4});
         end
      end
   endtask

   task automatic test_loopback;
      logic [7:0] b;
      logic [7:0] rx;
      int         n;
      bit         ok;
      for (int i = 0; i < 256; i++) begin
         b = 8'($urandom);
         n = 0;
         @(posedge clk); #1;
         while (rdy16 !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
         end
         checks++;
         if (rdy16 !== 1'b1) begin
            errors++;
            $display("FAIL loop_ready frame %0d got %b want 1", i, rdy16);
            return;
         end
         v16 = 1'b1;
         d16 = b;
         @(posedge clk); #1;
         v16 = 1'b0;
         ok = 1'b0;
         for (int w = 0; w < 4 && !ok; w++) begin
            @(negedge clk);
            if (out16 === 1'b0) ok = 1'b1;
         end
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL loop_start frame %0d got 1 want 0", i);
            return;
         end
         repeat (8) @(negedge clk);
         checks++;
         if (out16 !== 1'b0) begin
            errors++;
            $display("FAIL loop_startmid frame %0d got %b want 0", i, out16);
         end
         for (int j = 0; j < 8; j++) begin
            repeat (16) @(negedge clk);
            rx[j] = out16;
         end
         repeat (16) @(negedge clk);
         checks++;
         if (out16 !== 1'b1) begin
            errors++;
            $display("FAIL loop_stop frame %0d got %b want 1", i, out16);
         end
         checks++;
         if (rx !== b) begin
            errors++;
            $display("FAIL loop_data frame %0d got %h want %h", i, rx, b);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single(8'hA5);
      repeat (4) test_single(8'($urandom));
      test_back_to_back();
      test_busy_protect();
      test_reset_mid();
      test_loopback();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
